bp_cce_pending_bits: RTL and testbench

// - Pending-bit store for the CCE. Receives the arbitrated pending-bit write stream and the pending-bit read stream.
// - Holds one saturating counter per way-group. A way-group is pending while its counter is non-zero.
// - Increment and decrement are the microcode and auto-forward pending set/clear operations.
// - Read results feed the instruction decoder's pending-flag register, one cycle after the request.

---
 rtl/bp_cce_pkg.sv | 47 ++++
 rtl/bp_cce_pending_idx.sv | 27 ++
 rtl/bp_cce_pending_bits.sv | 100 ++++++++++
 tb/tb_bp_cce_pending_bits.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_pkg.sv
// Shared types and helpers for the CCE pending-bit store: counter step result and address hash.
// Purely combinational definitions; no state, no flow control.
package bp_cce_pkg;

  localparam int unsigned bp_cce_cnt_max_width_gp  = 16;
  localparam int unsigned bp_cce_addr_max_width_gp = 128;

  typedef struct packed {
    logic [bp_cce_cnt_max_width_gp-1:0] cnt;
    logic                               err;
  } bp_cce_pending_cnt_s;

  // Folds the L bits above the offset field onto the next L bits to spread interleaved blocks.
  function automatic logic [15:0] bp_cce_hash_idx(
    input logic [bp_cce_addr_max_width_gp-1:0] addr,
    input int unsigned                         base,
    input int unsigned                         lg
  );
    logic [bp_cce_addr_max_width_gp-1:0] mask;
    logic [bp_cce_addr_max_width_gp-1:0] lo;
    logic [bp_cce_addr_max_width_gp-1:0] hi;
    mask = (bp_cce_addr_max_width_gp'(1) << lg) - bp_cce_addr_max_width_gp'(1);
    lo   = (addr >> base) & mask;
    hi   = (addr >> (base + lg)) & mask;
    return 16'(lo ^ hi);
  endfunction

  // Saturating step: a blocked inc/dec keeps the count and raises err.
  function automatic bp_cce_pending_cnt_s bp_cce_cnt_step(
    input logic [bp_cce_cnt_max_width_gp-1:0] cur,
    input logic [bp_cce_cnt_max_width_gp-1:0] max_cnt,
    input logic                               inc
  );
    bp_cce_pending_cnt_s res;
    res.cnt = cur;
    res.err = 1'b0;
    if (inc) begin
      if (cur == max_cnt) res.err = 1'b1;
      else                res.cnt = cur + 1'b1;
    end else begin
      if (cur == '0) res.err = 1'b1;
      else           res.cnt = cur - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_cce_pending_idx.sv
// Address to way-group index, direct or hashed; combinational, zero latency.
// No flow control: the index follows the address and bypass bit every cycle.
module bp_cce_pending_idx
  import bp_cce_pkg::*;
#(
  parameter int paddr_width_p = 40,
  parameter int lg_groups_p   = 6,
  parameter int offset_p      = 6,
  parameter int cce_bits_p    = 0
) (
  input  logic [paddr_width_p-1:0] addr,
  input  logic                     bypass,
  output logic [lg_groups_p-1:0]   idx
);

  logic [bp_cce_addr_max_width_gp-1:0] addr_ext;
  logic [15:0]                         hash;
  logic                                unused_hash;

  assign addr_ext    = bp_cce_addr_max_width_gp'(addr);
  assign hash        = bp_cce_hash_idx(addr_ext, offset_p + cce_bits_p, lg_groups_p);
  assign unused_hash = ^hash;

  // Bypass indexes straight off the block offset and ignores CCE interleave bits.
  assign idx = bypass ? addr_ext[offset_p +: lg_groups_p] : hash[lg_groups_p-1:0];

endmodule

// File: rtl/bp_cce_pending_bits.sv
// Pending-bit store: saturating counter per way-group, writes land at the edge, reads return 1 cycle later.
// Never stalls; same-idx read sees the pre-write count unless BP_CCE_PENDING_FWD_EN is defined.
module bp_cce_pending_bits
  import bp_cce_pkg::*;
#(
  parameter int num_way_groups_p = 64,
  parameter int paddr_width_p    = 40,
  parameter int block_width_p    = 512,
  parameter int num_cce_p        = 1,
  parameter int cnt_width_p      = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     w_v_i,
  input  logic [paddr_width_p-1:0] w_addr_i,
  input  logic                     w_addr_bypass_i,
  input  logic                     pending_i,
  input  logic                     r_v_i,
  input  logic [paddr_width_p-1:0] r_addr_i,
  input  logic                     r_addr_bypass_i,
  output logic                     pending_v_o,
  output logic                     pending_o,
  output logic                     error_o
);

  localparam int lg_groups_lp = $clog2(num_way_groups_p);
  localparam int offset_lp    = $clog2(block_width_p / 8);
  localparam int cce_bits_lp  = (num_cce_p > 1) ? $clog2(num_cce_p) : 0;
  localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;

  logic [lg_groups_lp-1:0] w_idx;
  logic [lg_groups_lp-1:0] r_idx;
  logic [cnt_width_p-1:0]  cnt_r [num_way_groups_p];
  bp_cce_pending_cnt_s     w_step;
  logic [cnt_width_p-1:0]  w_nxt;
  logic [cnt_width_p-1:0]  r_val;
  logic                    unused_step;

  bp_cce_pending_idx #(
    .paddr_width_p(paddr_width_p),
    .lg_groups_p  (lg_groups_lp),
    .offset_p     (offset_lp),
    .cce_bits_p   (cce_bits_lp)
  ) w_idx_inst (
    .addr  (w_addr_i),
    .bypass(w_addr_bypass_i),
    .idx   (w_idx)
  );

  bp_cce_pending_idx #(
    .paddr_width_p(paddr_width_p),
    .lg_groups_p  (lg_groups_lp),
    .offset_p     (offset_lp),
    .cce_bits_p   (cce_bits_lp)
  ) r_idx_inst (
    .addr  (r_addr_i),
    .bypass(r_addr_bypass_i),
    .idx   (r_idx)
  );

  always_comb begin
    w_step = bp_cce_cnt_step(bp_cce_cnt_max_width_gp'(cnt_r[w_idx]),
                             bp_cce_cnt_max_width_gp'(cnt_max_lp),
                             pending_i);
  end

  assign w_nxt       = w_step.cnt[cnt_width_p-1:0];
  assign unused_step = ^w_step.cnt;

`ifdef BP_CCE_PENDING_FWD_EN
  assign r_val = (w_v_i && (w_idx == r_idx)) ? w_nxt : cnt_r[r_idx];
`else
  assign r_val = cnt_r[r_idx];
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_way_groups_p; i++) cnt_r[i] <= '0;
    end else if (w_v_i) begin
      cnt_r[w_idx] <= w_nxt;
    end
  end

  // pending_o holds its last result across idle cycles; only pending_v_o marks freshness.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_v_o <= 1'b0;
      pending_o   <= 1'b0;
    end else begin
      pending_v_o <= r_v_i;
      if (r_v_i) pending_o <= (r_val != '0);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) error_o <= 1'b0;
    else if (w_v_i && w_step.err) error_o <= 1'b1;
  end

endmodule

// File: tb/tb_bp_cce_pending_bits.sv
// Bench for bp_cce_pending_bits: directed table, saturation/forwarding/reset sequences, random vs. model.
module tb_bp_cce_pending_bits;

`ifdef BP_CCE_PENDING_FWD_EN
  localparam bit fwd = 1'b1;
`else
  localparam bit fwd = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        w_v_i;
  logic [39:0] w_addr_i;
  logic        w_addr_bypass_i;
  logic        pending_i;
  logic        r_v_i;
  logic [39:0] r_addr_i;
  logic        r_addr_bypass_i;
  logic        pending_v_o;
  logic        pending_o;
  logic        error_o;

  bp_cce_pending_bits dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .w_v_i          (w_v_i),
    .w_addr_i       (w_addr_i),
    .w_addr_bypass_i(w_addr_bypass_i),
    .pending_i      (pending_i),
    .r_v_i          (r_v_i),
    .r_addr_i       (r_addr_i),
    .r_addr_bypass_i(r_addr_bypass_i),
    .pending_v_o    (pending_v_o),
    .pending_o      (pending_o),
    .error_o        (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: one integer count per way-group, limits 0..15.
  int unsigned m_cnt [64];
  bit          m_err;
  bit          m_p;
  bit          m_pv;

  typedef struct {
    bit          wv;
    logic [39:0] waddr;
    bit          wbyp;
    bit          inc;
    bit          rv;
    logic [39:0] raddr;
    bit          rbyp;
    bit          epv;
    bit          ep;
    bit          eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [39:0] a, input bit byp);
    longint unsigned v;
    int lo, hi;
    v  = 64'(a);
    lo = int'((v >> 6) % 64);
    hi = int'((v >> 12) % 64);
    return byp ? lo : (lo ^ hi);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_cnt[i] = 0;
    m_err = 0;
    m_p   = 0;
    m_pv  = 0;
  endtask

  task automatic step(input bit wv, input logic [39:0] wa, input bit wb, input bit inc,
                      input bit rv, input logic [39:0] ra, input bit rb);
    int wi, ri;
    int unsigned pre, post;
    @(negedge clk_i);
    w_v_i = wv; w_addr_i = wa; w_addr_bypass_i = wb; pending_i = inc;
    r_v_i = rv; r_addr_i = ra; r_addr_bypass_i = rb;
    @(posedge clk_i);
    wi  = idx_of(wa, wb);
    ri  = idx_of(ra, rb);
    pre = m_cnt[ri];
    if (wv) begin
      if (inc) begin
        if (m_cnt[wi] == 15) m_err = 1; else m_cnt[wi] = m_cnt[wi] + 1;
      end else begin
        if (m_cnt[wi] == 0) m_err = 1; else m_cnt[wi] = m_cnt[wi] - 1;
      end
    end
    post = m_cnt[ri];
    m_pv = rv;
    if (rv) m_p = fwd ? (post != 0) : (pre != 0);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pending_v"}, pending_v_o, m_pv);
    chk({tag, ".pending"},   pending_o,   m_p);
    chk({tag, ".error"},     error_o,     m_err);
  endtask

  task automatic hw_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    w_v_i = 0; r_v_i = 0;
    model_clear();
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  function automatic logic [39:0] rnd_addr();
    logic [39:0] a;
    a = (40'($urandom) << 20) | (40'($urandom_range(0, 3)) << 12) |
        (40'($urandom_range(0, 7)) << 6) | 40'($urandom_range(0, 63));
    return a;
  endfunction

  localparam logic [39:0] addr_x = 40'h1040;  // idx 1 direct, idx 0 hashed
  localparam logic [39:0] addr_a = 40'h2000;  // idx 0
  localparam logic [39:0] addr_b = 40'h03C0;  // idx 15
  localparam logic [39:0] addr_c = 40'h0500;  // idx 20
  localparam logic [39:0] addr_d = 40'h07C0;  // idx 31
  localparam logic [39:0] addr_p = 40'h0140;  // idx 5

  initial begin
    logic [39:0] ra;
    model_clear();
    // Reset held with writes and reads asserted.
    reset_n_i = 1'b0;
    w_v_i = 1; w_addr_i = addr_x; w_addr_bypass_i = 1; pending_i = 1;
    r_v_i = 1; r_addr_i = addr_x; r_addr_bypass_i = 1;
    #1;
    chk("rst_t0.pending_v", pending_v_o, 0);
    chk("rst_t0.error", error_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("rst.pending_v", pending_v_o, 0);
      chk("rst.pending", pending_o, 0);
      chk("rst.error", error_o, 0);
    end
    @(negedge clk_i);
    w_v_i = 0; r_v_i = 0;
    reset_n_i = 1'b1;
    step(0, 0, 0, 0, 1, addr_x, 1);
    chk("post_rst.pending_v", pending_v_o, 1);
    chk("post_rst.pending", pending_o, 0);

    //                wv waddr  wb inc rv raddr  rb   pv p err
    tbl.push_back('{1, addr_x, 1, 1, 0, 0,      0,   0, 0, 0});
    tbl.push_back('{0, 0,      0, 0, 1, addr_x, 0,   1, 0, 0});
    tbl.push_back('{0, 0,      0, 0, 1, addr_x, 1,   1, 1, 0});
    tbl.push_back('{0, 0,      0, 0, 0, 0,      0,   0, 1, 0});
    tbl.push_back('{1, addr_a, 1, 1, 0, 0,      0,   0, 1, 0});
    tbl.push_back('{1, addr_a, 1, 1, 0, 0,      0,   0, 1, 0});
    tbl.push_back('{1, addr_a, 1, 1, 1, addr_x, 1,   1, 1, 0});
    tbl.push_back('{0, 0,      0, 0, 1, addr_a, 1,   1, 1, 0});
    tbl.push_back('{1, addr_a, 1, 0, 1, addr_x, 1,   1, 1, 0});
    tbl.push_back('{0, 0,      0, 0, 1, addr_a, 1,   1, 1, 0});
    tbl.push_back('{1, addr_a, 1, 0, 0, 0,      0,   0, 1, 0});
    tbl.push_back('{0, 0,      0, 0, 1, addr_a, 1,   1, 1, 0});
    tbl.push_back('{1, addr_a, 1, 0, 0, 0,      0,   0, 1, 0});
    tbl.push_back('{0, 0,      0, 0, 1, addr_a, 1,   1, 0, 0});
    foreach (tbl[i]) begin
      step(tbl[i].wv, tbl[i].waddr, tbl[i].wbyp, tbl[i].inc, tbl[i].rv, tbl[i].raddr, tbl[i].rbyp);
      chk($sformatf("tbl%0d.pending_v", i), pending_v_o, tbl[i].epv);
      chk($sformatf("tbl%0d.pending", i),   pending_o,   tbl[i].ep);
      chk($sformatf("tbl%0d.error", i),     error_o,     tbl[i].eerr);
    end

    // Saturation: error only on the 16th inc, count then drains in exactly 15 decs.
    for (int i = 1; i <= 16; i++) begin
      step(1, addr_b, 1, 1, 0, 0, 0);
      chk($sformatf("sat_inc%0d.error", i), error_o, (i == 16));
    end
    for (int i = 0; i < 14; i++) step(1, addr_b, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, addr_b, 1);
    chk("sat_dec14.pending", pending_o, 1);
    step(1, addr_b, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, addr_b, 1);
    chk("sat_dec15.pending", pending_o, 0);
    chk("sat_sticky.error", error_o, 1);

    // Underflow on a fresh store.
    hw_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    chk("udf_pre.error", error_o, 0);
    step(1, addr_c, 1, 0, 0, 0, 0);
    chk("udf.error", error_o, 1);
    step(0, 0, 0, 0, 1, addr_c, 1);
    chk("udf_hold.pending", pending_o, 0);

    // Same-cycle inc and read of an idle group.
    step(1, addr_d, 1, 1, 1, addr_d, 1);
    chk("fwd_same.pending", pending_o, fwd);
    step(0, 0, 0, 0, 1, addr_d, 1);
    chk("fwd_next.pending", pending_o, 1);

    // Random traffic against the model.
    hw_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), rnd_addr(), $urandom_range(0, 1), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 1), rnd_addr(), $urandom_range(0, 1));
      chk_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-stream, between clock edges.
    hw_reset();
    step(1, addr_p, 1, 1, 0, 0, 0);
    step(1, addr_p, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      ra = (i % 3 == 0) ? addr_p : (40'($urandom_range(32, 63)) << 6);
      step(1, 40'($urandom_range(32, 63)) << 6, 1, $urandom_range(0, 1), 1, ra, 1);
      chk_model($sformatf("mid%0d", i));
    end
    step(0, 0, 0, 0, 1, addr_p, 1);
    chk("mid_pre.pending", pending_o, 1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst.pending_v", pending_v_o, 0);
    chk("mid_rst.pending", pending_o, 0);
    chk("mid_rst.error", error_o, 0);
    model_clear();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(0, 0, 0, 0, 1, addr_p, 1);
    chk("mid_post.pending_v", pending_v_o, 1);
    chk("mid_post.pending", pending_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
